// File: rtl/rv32i_adder_issue_arb_if.sv
// Issue bus between N requesters, the arbiter and the shared adder.
// Request side: i_req_* in, o_req_rdy out. Adder side: o_* out, i_rdy in.
interface rv32i_adder_issue_arb_if #(
  parameter int N_REQ  = 4,
  parameter int TAG_BW = 6,
  parameter int ROB_BW = 5
);
  logic [N_REQ-1:0]             i_req_vld;
  logic [N_REQ-1:0]             i_req_sub_flag;
  logic [N_REQ-1:0][31:0]       i_req_a;
  logic [N_REQ-1:0][31:0]       i_req_b;
  logic [N_REQ-1:0][TAG_BW-1:0] i_req_dst_tag;
  logic [N_REQ-1:0][ROB_BW-1:0] i_req_rob_idx;
  logic [N_REQ-1:0]             o_req_rdy;
  logic                         o_vld;
  logic                         o_sub_flag;
  logic [31:0]                  o_a;
  logic [31:0]                  o_b;
  logic [TAG_BW-1:0]            o_dst_tag;
  logic [ROB_BW-1:0]            o_rob_idx;
  logic                         i_rdy;

  modport master (
    output i_req_vld, i_req_sub_flag,
    output i_req_a, i_req_b,
    output i_req_dst_tag, i_req_rob_idx,
    output i_rdy,
    input  o_req_rdy, o_vld, o_sub_flag,
    input  o_a, o_b, o_dst_tag, o_rob_idx
  );

  modport slave (
    input  i_req_vld, i_req_sub_flag,
    input  i_req_a, i_req_b,
    input  i_req_dst_tag, i_req_rob_idx,
    input  i_rdy,
    output o_req_rdy, o_vld, o_sub_flag,
    output o_a, o_b, o_dst_tag, o_rob_idx
  );
endinterface

// File: rtl/rv32i_adder_issue_arb.sv
// Round-robin issue arbiter feeding one rv32i_adder via a 1-entry stage.
// Ports: clk, rstn (sync, active-low), i_flush, bus (slave modport);
// o_grant_cnt only when RV32I_ADD_ARB_PERF_CNT_EN is defined.
package rv32i_pkg;
  localparam int PHYS_REG_FILE_IDX_BW = 6;
  localparam int ROB_DEPTH            = 32;
endpackage

module rv32i_adder_issue_arb
  import rv32i_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_flush,
  rv32i_adder_issue_arb_if.slave bus
`ifdef RV32I_ADD_ARB_PERF_CNT_EN
  ,
  output logic [N_REQ-1:0][31:0] o_grant_cnt
`endif
);

  localparam int PTR_BW = $clog2(N_REQ);
  localparam int TAG_BW = PHYS_REG_FILE_IDX_BW;
  localparam int ROB_BW = $clog2(ROB_DEPTH);

  logic              r_vld;
  logic              r_sub;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [TAG_BW-1:0] r_tag;
  logic [ROB_BW-1:0] r_rob;
  logic [PTR_BW-1:0] r_ptr;

  logic              w_can_acc;
  logic              w_found;
  logic [PTR_BW-1:0] w_win;
  logic              w_grant;
  logic [N_REQ-1:0]  w_rdy;

  // N_REQ need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_BW-1:0] wrap_add(
    input logic [PTR_BW-1:0] p,
    input int                k
  );
    int s;
    s = (int'(p) + k) % N_REQ;
    return PTR_BW'(s);
  endfunction

  assign w_can_acc = ~r_vld | bus.i_rdy;

  // Scan from farthest to nearest so the requester closest
  // to the pointer is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.i_req_vld[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_ptr, k);
      end
    end
  end

  // No transfer while in reset or flushing.
  assign w_grant = rstn & w_found & w_can_acc & ~i_flush;

  always_comb begin
    w_rdy = '0;
    if (w_grant) w_rdy[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vld <= 1'b0;
      r_sub <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= '0;
      r_rob <= '0;
      r_ptr <= '0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (w_grant) begin
      r_vld <= 1'b1;
      r_sub <= bus.i_req_sub_flag[w_win];
      r_a   <= bus.i_req_a[w_win];
      r_b   <= bus.i_req_b[w_win];
      r_tag <= bus.i_req_dst_tag[w_win];
      r_rob <= bus.i_req_rob_idx[w_win];
      r_ptr <= wrap_add(w_win, 1);
    end else if (bus.i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.o_req_rdy  = w_rdy;
  assign bus.o_vld      = r_vld;
  assign bus.o_sub_flag = r_sub;
  assign bus.o_a        = r_a;
  assign bus.o_b        = r_b;
  assign bus.o_dst_tag  = r_tag;
  assign bus.o_rob_idx  = r_rob;

`ifdef RV32I_ADD_ARB_PERF_CNT_EN
  logic [N_REQ-1:0][31:0] r_cnt;

  // Flush does not clear the counters; only reset does.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cnt[w_win] <= r_cnt[w_win] + 32'd1;
    end
  end

  assign o_grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_rv32i_adder_issue_arb.sv
// Self-checking bench for rv32i_adder_issue_arb.
// Directed scenarios plus a randomized run against a reference model.
module tb_rv32i_adder_issue_arb;
  import rv32i_pkg::*;

  localparam int N      = 4;
  localparam int TAG_BW = PHYS_REG_FILE_IDX_BW;
  localparam int ROB_BW = $clog2(ROB_DEPTH);

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  always #5 clk = ~clk;

  rv32i_adder_issue_arb_if #(
    .N_REQ (N),
    .TAG_BW(TAG_BW),
    .ROB_BW(ROB_BW)
  ) bus ();

`ifdef RV32I_ADD_ARB_PERF_CNT_EN
  logic [N-1:0][31:0] grant_cnt;
`endif

  rv32i_adder_issue_arb #(.N_REQ(N)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_flush(flush),
    .bus    (bus)
`ifdef RV32I_ADD_ARB_PERF_CNT_EN
    ,
    .o_grant_cnt(grant_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  bit              m_vld = 1'b0;
  bit              m_sub = 1'b0;
  logic [31:0]     m_a   = '0;
  logic [31:0]     m_b   = '0;
  logic [TAG_BW-1:0] m_tag = '0;
  logic [ROB_BW-1:0] m_rob = '0;
  int              m_ptr = 0;
  int unsigned     m_cnt [N];

  // Who should be granted this cycle, or -1.
  function automatic int exp_win();
    if (!rstn || flush) return -1;
    if (m_vld && !bus.i_rdy) return -1;
    for (int k = 0; k < N; k++) begin
      if (bus.i_req_vld[(m_ptr + k) % N])
        return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    int g;
    g = exp_win();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
  endfunction

  task automatic model_clock();
    int g;
    g = exp_win();
    if (!rstn) begin
      m_vld = 0; m_sub = 0; m_a = '0; m_b = '0;
      m_tag = '0; m_rob = '0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (flush) begin
      m_vld = 0;
    end else if (g >= 0) begin
      m_vld = 1;
      m_sub = bus.i_req_sub_flag[g];
      m_a   = bus.i_req_a[g];
      m_b   = bus.i_req_b[g];
      m_tag = bus.i_req_dst_tag[g];
      m_rob = bus.i_req_rob_idx[g];
      m_ptr = (g + 1) % N;
      m_cnt[g] = m_cnt[g] + 1;
    end else if (bus.i_rdy) begin
      m_vld = 0;
    end
  endtask

  task automatic tick();
    model_clock();
    @(negedge clk);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      bus.i_req_a[i]        = $urandom;
      bus.i_req_b[i]        = $urandom;
      bus.i_req_sub_flag[i] = 1'($urandom);
      bus.i_req_dst_tag[i]  = TAG_BW'($urandom);
      bus.i_req_rob_idx[i]  = ROB_BW'($urandom);
    end
  endtask

  task automatic test_reset();
    bus.i_req_vld = '1;
    bus.i_rdy = 1'b1;
    rand_payload();
    rstn = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (bus.o_vld !== 1'b0) begin
      errors++;
      $display("FAIL rst_vld got %b want 0", bus.o_vld);
    end
    checks++;
    if (bus.o_req_rdy !== '0) begin
      errors++;
      $display("FAIL rst_rdy got %b want 0", bus.o_req_rdy);
    end
    checks++;
    if ({bus.o_a, bus.o_b, bus.o_sub_flag} !== '0 ||
        {bus.o_dst_tag, bus.o_rob_idx} !== '0) begin
      errors++;
      $display("FAIL rst_payload got a=%h b=%h s=%b t=%h r=%h want 0",
               bus.o_a, bus.o_b, bus.o_sub_flag,
               bus.o_dst_tag, bus.o_rob_idx);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.o_req_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL rst_first got %b want 0001", bus.o_req_rdy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    int p;
    for (int i = 0; i < N; i++)
      bus.i_req_rob_idx[i] = ROB_BW'(i * 3 + 1);
    bus.i_req_vld = '1;
    bus.i_rdy = 1'b1;
    flush = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      e = '0;
      e[c % N] = 1'b1;
      checks++;
      if (bus.o_req_rdy !== e) begin
        errors++;
        $display("FAIL rr_grant c%0d got %b want %b",
                 c, bus.o_req_rdy, e);
      end
      checks++;
      if (bus.o_vld !== (c != 0)) begin
        errors++;
        $display("FAIL rr_vld c%0d got %b want %b",
                 c, bus.o_vld, c != 0);
      end
      if (c > 0) begin
        p = (c + N - 1) % N;
        checks++;
        if (bus.o_rob_idx !== ROB_BW'(p * 3 + 1) ||
            bus.o_a !== bus.i_req_a[p]) begin
          errors++;
          $display("FAIL rr_payload c%0d got rob=%0d want %0d",
                   c, bus.o_rob_idx, p * 3 + 1);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    bus.i_req_vld = 4'b0010;
    bus.i_req_a[1] = 32'd5;
    bus.i_req_b[1] = 32'd3;
    bus.i_req_sub_flag[1] = 1'b1;
    bus.i_rdy = 1'b1;
    #1;
    checks++;
    if (bus.o_req_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL st_load got %b want 0010", bus.o_req_rdy);
    end
    tick();
    bus.i_req_vld = '1;
    bus.i_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.i_req_a[1] = $urandom;
      #1;
      checks++;
      if (bus.o_req_rdy !== '0 || bus.o_vld !== 1'b1) begin
        errors++;
        $display("FAIL st_hold c%0d got rdy=%b vld=%b want 0000 1",
                 c, bus.o_req_rdy, bus.o_vld);
      end
      checks++;
      if (bus.o_a !== 32'd5 || bus.o_b !== 32'd3 ||
          bus.o_sub_flag !== 1'b1) begin
        errors++;
        $display("FAIL st_data c%0d got a=%0d b=%0d s=%b want 5 3 1",
                 c, bus.o_a, bus.o_b, bus.o_sub_flag);
      end
      tick();
    end
    bus.i_rdy = 1'b1;
    #1;
    checks++;
    if (bus.o_req_rdy !== 4'b0100) begin
      errors++;
      $display("FAIL st_release got %b want 0100", bus.o_req_rdy);
    end
    tick();
    #1;
    checks++;
    if (bus.o_req_rdy !== 4'b1000 || bus.o_a !== bus.i_req_a[2]) begin
      errors++;
      $display("FAIL st_ptr3 got %b want 1000", bus.o_req_rdy);
    end
    tick();
  endtask

  task automatic test_skip_idle();
    bus.i_rdy = 1'b1;
    bus.i_req_vld = 4'b0001;
    #1;
    checks++;
    if (bus.o_req_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL sk_pre got %b want 0001", bus.o_req_rdy);
    end
    tick();
    bus.i_req_vld = 4'b1001;
    #1;
    checks++;
    if (bus.o_req_rdy !== 4'b1000) begin
      errors++;
      $display("FAIL sk_req3 got %b want 1000", bus.o_req_rdy);
    end
    tick();
    #1;
    checks++;
    if (bus.o_req_rdy !== 4'b0001 || bus.o_a !== bus.i_req_a[3]) begin
      errors++;
      $display("FAIL sk_req0 got %b want 0001", bus.o_req_rdy);
    end
    tick();
  endtask

  task automatic test_flush();
    bus.i_req_vld = 4'b0100;
    bus.i_rdy = 1'b0;
    flush = 1'b1;
    #1;
    checks++;
    if (bus.o_req_rdy !== '0 || bus.o_vld !== 1'b1) begin
      errors++;
      $display("FAIL fl_block got rdy=%b vld=%b want 0000 1",
               bus.o_req_rdy, bus.o_vld);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (bus.o_vld !== 1'b0 || bus.o_req_rdy !== 4'b0100) begin
      errors++;
      $display("FAIL fl_after got vld=%b rdy=%b want 0 0100",
               bus.o_vld, bus.o_req_rdy);
    end
    tick();
    #1;
    checks++;
    if (bus.o_vld !== 1'b1 || bus.o_a !== bus.i_req_a[2] ||
        bus.o_rob_idx !== bus.i_req_rob_idx[2]) begin
      errors++;
      $display("FAIL fl_req2 got vld=%b a=%h want 1 %h",
               bus.o_vld, bus.o_a, bus.i_req_a[2]);
    end
    flush = 1'b1;
    bus.i_rdy = 1'b1;
    bus.i_req_vld = '1;
    #1;
    checks++;
    if (bus.o_req_rdy !== '0) begin
      errors++;
      $display("FAIL fl_override got %b want 0000", bus.o_req_rdy);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (bus.o_vld !== 1'b0) begin
      errors++;
      $display("FAIL fl_kill got %b want 0", bus.o_vld);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] e;
    for (int c = 0; c < 400; c++) begin
      rstn  = ($urandom_range(0, 63) != 0);
      flush = ($urandom_range(0, 15) == 0);
      bus.i_rdy = ($urandom_range(0, 3) != 0);
      bus.i_req_vld = N'($urandom);
      rand_payload();
      #1;
      e = exp_rdy();
      checks++;
      if (bus.o_req_rdy !== e) begin
        errors++;
        $display("FAIL rnd_rdy c%0d got %b want %b",
                 c, bus.o_req_rdy, e);
      end
      checks++;
      if (bus.o_vld !== m_vld) begin
        errors++;
        $display("FAIL rnd_vld c%0d got %b want %b",
                 c, bus.o_vld, m_vld);
      end
      if (m_vld) begin
        checks++;
        if (bus.o_a !== m_a || bus.o_b !== m_b ||
            bus.o_sub_flag !== m_sub ||
            bus.o_dst_tag !== m_tag ||
            bus.o_rob_idx !== m_rob) begin
          errors++;
          $display("FAIL rnd_data c%0d got a=%h b=%h want %h %h",
                   c, bus.o_a, bus.o_b, m_a, m_b);
        end
      end
`ifdef RV32I_ADD_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) begin
        checks++;
        if (grant_cnt[i] !== m_cnt[i]) begin
          errors++;
          $display("FAIL rnd_cnt%0d c%0d got %0d want %0d",
                   i, c, grant_cnt[i], m_cnt[i]);
        end
      end
`endif
      tick();
    end
    rstn = 1'b1;
    flush = 1'b0;
  endtask

`ifdef RV32I_ADD_ARB_PERF_CNT_EN
  task automatic test_perf();
    logic [N-1:0] v;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    bus.i_rdy = 1'b1;
    for (int t = 0; t < 10; t++) begin
      v = (t % 2 == 1) ? 4'b0100 : 4'b0001;
      bus.i_req_vld = v;
      #1;
      checks++;
      if (bus.o_req_rdy !== v) begin
        errors++;
        $display("FAIL pf_grant t%0d got %b want %b",
                 t, bus.o_req_rdy, v);
      end
      tick();
    end
    bus.i_req_vld = '0;
    #1;
    checks++;
    if (grant_cnt[0] !== 32'd5 || grant_cnt[1] !== 32'd0 ||
        grant_cnt[2] !== 32'd5 || grant_cnt[3] !== 32'd0) begin
      errors++;
      $display("FAIL pf_cnt got %0d %0d %0d %0d want 5 0 5 0",
               grant_cnt[0], grant_cnt[1],
               grant_cnt[2], grant_cnt[3]);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (grant_cnt[0] !== 32'd5 || grant_cnt[2] !== 32'd5) begin
      errors++;
      $display("FAIL pf_flush got %0d %0d want 5 5",
               grant_cnt[0], grant_cnt[2]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rstn = 1'b0;
    flush = 1'b0;
    bus.i_rdy = 1'b1;
    bus.i_req_vld = '0;
    rand_payload();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_stall();
    test_skip_idle();
    test_flush();
    test_random();
`ifdef RV32I_ADD_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
